// File: rtl/tmac_pkg.sv
// tmac_pkg: shared types and helpers for the tmac_seq temporal MAC.
//   state_e : top-level FSM states
//   rev()   : reverses the low w bits of x (van der Corput index sequence)
//   S/L/RW  : derived constants for the default N=16, W=8 configuration
package tmac_pkg;

  localparam int N_DEF = 16;
  localparam int W_DEF = 8;
  localparam int S     = $clog2(N_DEF);
  localparam int L     = N_DEF << W_DEF;
  localparam int RW    = W_DEF + S + 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  // Shifting x[0] in first leaves it at bit w-1, x[w-1] at bit 0.
  function automatic logic [31:0] rev(input logic [31:0] x, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++)
      if (i < w) r = {r[30:0], x[i]};
    return r;
  endfunction

endpackage

// File: rtl/tmac_lane.sv
// tmac_lane: one unipolar product lane.
//   clk, rst_n : clock, async active-low reset
//   ld_i       : capture a_i/b_i into the operand registers
//   a_i, b_i   : rate-coded / temporal-coded operands
//   j_i        : stream index
//   bit_o      : lane stream bit at index j_i (combinational from registers)
module tmac_lane
  import tmac_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] j_i,
  output logic         bit_o
);

  logic [W-1:0] a_q, b_q;
  logic [W-1:0] rj;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else if (ld_i) begin
      a_q <= a_i;
      b_q <= b_i;
    end
  end

  // Rate code compares A against a low-discrepancy sequence; the temporal
  // code gates the first B indices.
  assign rj    = W'(rev(32'(j_i), W));
  assign bit_o = (a_q > rj) && (j_i < b_q);

endmodule

// File: rtl/tmac_seq.sv
// tmac_seq: deterministic N-lane scaled unipolar temporal MAC.
//   clk, rst_n : clock, async active-low reset
//   start      : run request, sampled in IDLE only
//   en         : advance enable; low stalls a run
//   iA, iB     : per-lane operands, captured when start is accepted
//   oC, oValid : registered output stream bit and its qualifier
//   busy       : high while running
//   done       : one-cycle pulse at run completion
//   result     : ones count of the last completed run
module tmac_seq
  import tmac_pkg::*;
#(
  parameter int N = 16,
  parameter int W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  en,
  input  logic [W-1:0]          iA [N-1:0],
  input  logic [W-1:0]          iB [N-1:0],
  output logic                  oC,
  output logic                  oValid,
  output logic                  busy,
  output logic                  done,
  output logic [W+$clog2(N):0]  result
);

  localparam int SEL_W = $clog2(N);
  localparam int KW    = SEL_W + W;
  localparam int RES_W = W + SEL_W + 1;

  state_e             state_q;
  logic [KW-1:0]      k_q;
  logic [RES_W-1:0]   acc_q, acc_d, result_q;
  logic               oC_q, oValid_q, done_q;
  logic [N-1:0]       lane_bit;
  logic               ld, cur, last;

  assign ld    = (state_q == IDLE) && start;
  // Low bits of k pick the lane, high bits index the stream.
  assign cur   = lane_bit[k_q[SEL_W-1:0]];
  assign acc_d = acc_q + RES_W'(cur);
  assign last  = &k_q;

  for (genvar g = 0; g < N; g++) begin : g_lane
    tmac_lane #(.W(W)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .ld_i  (ld),
      .a_i   (iA[g]),
      .b_i   (iB[g]),
      .j_i   (k_q[KW-1:SEL_W]),
      .bit_o (lane_bit[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      oC_q     <= 1'b0;
      oValid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          oValid_q <= 1'b0;
          if (start) begin
            k_q     <= '0;
            acc_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (en) begin
            oC_q     <= cur;
            oValid_q <= 1'b1;
            acc_q    <= acc_d;
            k_q      <= k_q + KW'(1);
            if (last) begin
              // Final bit is folded into result on the same edge.
              result_q <= acc_d;
              done_q   <= 1'b1;
              state_q  <= IDLE;
            end
          end else begin
            oValid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign oC     = oC_q;
  assign oValid = oValid_q;
  assign busy   = (state_q == RUN);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_tmac_seq.sv
module tb_tmac_seq;
  localparam int N  = 16;
  localparam int W  = 8;
  localparam int L  = N << W;
  localparam int RW = W + $clog2(N) + 1;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, en = 1'b1;
  logic [W-1:0] iA [N-1:0];
  logic [W-1:0] iB [N-1:0];
  logic oC, oValid, busy, done;
  logic [RW-1:0] result;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  tmac_seq #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .en(en),
    .iA(iA), .iB(iB),
    .oC(oC), .oValid(oValid), .busy(busy), .done(done), .result(result)
  );

  function automatic int rev8(int x);
    int r = 0;
    for (int i = 0; i < W; i++) r = (r << 1) | ((x >> i) & 1);
    return r;
  endfunction

  function automatic int lane_bit(int a, int b, int j);
    return ((a > rev8(j)) && (j < b)) ? 1 : 0;
  endfunction

  // Closed-form sum of per-lane ones counts.
  function automatic int psum(input int a[N], input int b[N]);
    int s = 0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < b[i]; j++)
        if (rev8(j) < a[i]) s++;
    return s;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: run k indexes a lane (k mod N) and stream index (k / N).
  int mA[N], mB[N];
  int m_k, m_result, m_run, m_c, m_valid, m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_k = 0; m_c = 0; m_valid = 0; m_done = 0; m_result = 0;
      for (int i = 0; i < N; i++) begin mA[i] = 0; mB[i] = 0; end
    end else begin
      m_done = 0;
      if (m_run == 0) begin
        m_valid = 0;
        if (start) begin
          for (int i = 0; i < N; i++) begin mA[i] = int'(iA[i]); mB[i] = int'(iB[i]); end
          m_k = 0;
          m_run = 1;
        end
      end else if (en) begin
        m_c = lane_bit(mA[m_k % N], mB[m_k % N], m_k / N);
        m_valid = 1;
        m_k++;
        if (m_k == L) begin
          m_run = 0;
          m_done = 1;
          m_result = psum(mA, mB);
        end
      end else begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", int'(busy), m_run);
    chk("oValid", int'(oValid), m_valid);
    chk("done", int'(done), m_done);
    chk("result", int'(result), m_result);
    if (m_valid != 0) chk("oC", int'(oC), m_c);
  end

  int ea[N], eb[N];

  task automatic set_ops(input int a[N], input int b[N]);
    for (int i = 0; i < N; i++) begin iA[i] = W'(a[i]); iB[i] = W'(b[i]); end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      ea[i] = int'($urandom_range(0, 255));
      eb[i] = int'($urandom_range(0, 255));
    end
    set_ops(ea, eb);
  endtask

  task automatic launch();
    @(negedge clk);
    start = 1'b1;
  endtask

  // Waits for done from the run just launched; stall/poke indices of 0 disable.
  task automatic run_wait(input int stall_at, input int stall_len, input int poke_at,
                          output int cyc, output int vcnt, output int ones,
                          output int ones_off);
    bit got;
    int pa[N], pb[N];
    cyc = 0; vcnt = 0; ones = 0; ones_off = 0; got = 0;
    while (cyc < L + 200) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (oValid) begin
        if (oC) begin
          ones++;
          if (vcnt % N != 0) ones_off++;
        end
        vcnt++;
      end
      if (done) begin got = 1; break; end
      if (cyc == stall_at) en = 1'b0;
      if (cyc == stall_at + stall_len) en = 1'b1;
      if (cyc == poke_at) begin
        for (int i = 0; i < N; i++) begin
          pa[i] = int'($urandom_range(0, 255));
          pb[i] = int'($urandom_range(0, 255));
        end
        set_ops(pa, pb);
        start = 1'b1;
      end
    end
    en = 1'b1;
    chk("done_seen", int'(got), 1);
  endtask

  initial begin : main
    int cyc, vcnt, ones, off, exp1, exp2, dseen;
    for (int i = 0; i < N; i++) begin ea[i] = 0; eb[i] = 0; end
    set_ops(ea, eb);

    // Reset
    repeat (2) @(negedge clk);
    chk("rst_oC", int'(oC), 0);
    chk("rst_oValid", int'(oValid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    chk("idle_oValid", int'(oValid), 0);

    // All operands full scale
    for (int i = 0; i < N; i++) begin ea[i] = 255; eb[i] = 255; end
    set_ops(ea, eb);
    chk("model_full", psum(ea, eb), 4080);
    launch();
    run_wait(0, 0, 0, cyc, vcnt, ones, off);
    chk("full_latency", cyc, L + 1);
    chk("full_vcnt", vcnt, L);
    chk("full_result", int'(result), 4080);
    chk("full_busy_at_done", int'(busy), 0);
    @(negedge clk);
    chk("full_done_pulse", int'(done), 0);
    chk("full_oValid_drop", int'(oValid), 0);

    // Single lane 0 at half scale
    for (int i = 0; i < N; i++) begin ea[i] = 0; eb[i] = 0; end
    ea[0] = 128; eb[0] = 128;
    set_ops(ea, eb);
    chk("model_half", psum(ea, eb), 64);
    launch();
    run_wait(0, 0, 0, cyc, vcnt, ones, off);
    chk("half_result", int'(result), 64);
    chk("half_ones", ones, 64);
    chk("half_ones_off_lane0", off, 0);

    // Zero-product lanes
    for (int i = 0; i < N; i++) begin ea[i] = 0; eb[i] = 0; end
    ea[3] = 0; eb[3] = 255; ea[7] = 255; eb[7] = 0;
    set_ops(ea, eb);
    launch();
    run_wait(0, 0, 0, cyc, vcnt, ones, off);
    chk("zero_result", int'(result), 0);
    chk("zero_ones", ones, 0);

    // Random operands with a 10-cycle stall
    rand_ops();
    exp1 = psum(ea, eb);
    launch();
    run_wait(1000, 10, 0, cyc, vcnt, ones, off);
    chk("stall_latency", cyc, L + 11);
    chk("stall_vcnt", vcnt, L);
    chk("stall_result", int'(result), exp1);
    chk("stall_ones", ones, exp1);

    // start while busy is ignored
    rand_ops();
    exp1 = psum(ea, eb);
    launch();
    run_wait(0, 0, 2000, cyc, vcnt, ones, off);
    chk("poke_latency", cyc, L + 1);
    chk("poke_result", int'(result), exp1);

    // start coincident with done
    rand_ops();
    exp1 = psum(ea, eb);
    launch();
    run_wait(0, 0, 0, cyc, vcnt, ones, off);
    chk("b2b_first_result", int'(result), exp1);
    rand_ops();
    exp2 = psum(ea, eb);
    start = 1'b1;
    run_wait(0, 0, 0, cyc, vcnt, ones, off);
    chk("b2b_second_latency", cyc, L + 1);
    chk("b2b_second_result", int'(result), exp2);

    // Reset mid-run: no done, all outputs cleared
    rand_ops();
    launch();
    @(negedge clk);
    start = 1'b0;
    repeat (500) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_oValid", int'(oValid), 0);
    chk("mrst_oC", int'(oC), 0);
    chk("mrst_result", int'(result), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    dseen = 0;
    repeat (L + 100) begin
      @(negedge clk);
      if (done) dseen++;
    end
    chk("mrst_no_done", dseen, 0);
    chk("mrst_idle", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
